gh_fifo_wr_arb2: RTL

Two-requester, burst-limited round-robin arbiter that shares the write port of the 16-deep async FIFO (write side, `clk_WR` domain) between two producers. It grants one producer at a time. It forwards that producer's data and write strobe to the FIFO's `WR` and `D`, and it honours the FIFO `full` flag as backpressure. It caps each tenure at `burst_len` words so neither producer can starve the other.

---
 rtl/gh_fifo_arb_pkg.sv | 16 +
 rtl/gh_fifo_wr_arb2.sv | 112 +++++++++++
 2 files changed

// File: rtl/gh_fifo_arb_pkg.sv
// gh_fifo_arb_pkg
// Shared definitions for the FIFO write-port arbiters.
// Provides:
//   arb_state_e   - owner state encoding. The value is also the one-hot grant.
//   BURST_LEN_MAX - upper limit for burst_len. The beat counter is 4 bits wide.
package gh_fifo_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } arb_state_e;

    localparam int BURST_LEN_MAX = 15;

endpackage

// File: rtl/gh_fifo_wr_arb2.sv
// gh_fifo_wr_arb2
// Burst-limited round-robin arbiter for two producers that share the write
// port of gh_fifo_async16_sr. Each tenure is capped at burst_len words.
// Ports:
//   clk        write-side clock (the FIFO's clk_WR)
//   rst        synchronous active-high reset
//   REQ0/D0    producer 0 request/data; ACK0 pulses on each accepted word
//   REQ1/D1    producer 1 request/data; ACK1 pulses on each accepted word
//   full       FIFO full flag; acts as backpressure, owner keeps its grant
//   WR/D       FIFO write strobe and data
//   GNT        one-hot current owner (bit0 = producer 0)
import gh_fifo_arb_pkg::*;

module gh_fifo_wr_arb2 #(
    parameter int data_width = 8,
    parameter int burst_len  = 4   // 1..BURST_LEN_MAX
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  REQ0,
    input  logic [data_width-1:0] D0,
    output logic                  ACK0,
    input  logic                  REQ1,
    input  logic [data_width-1:0] D1,
    output logic                  ACK1,
    input  logic                  full,
    output logic                  WR,
    output logic [data_width-1:0] D,
    output logic [1:0]            GNT
);

    localparam logic [3:0] CNT_LAST = 4'(burst_len - 1);

    arb_state_e state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       last, last_nxt;   // 0: producer 0 served last, 1: producer 1

    logic own_req, oth_req, accept, release_now;

    // Accept is purely combinational. Gating by full means that a word can
    // never be accepted in the cycle full rises.
    assign ACK0 = (state == ST_OWN0) && REQ0 && !full;
    assign ACK1 = (state == ST_OWN1) && REQ1 && !full;
    assign WR   = ACK0 | ACK1;
    assign GNT  = {state == ST_OWN1, state == ST_OWN0};

    always_comb begin
        D = '0;
        if (state == ST_OWN0)
            D = D0;
        else if (state == ST_OWN1)
            D = D1;
    end

    // Request lines seen from the point of view of the current owner.
    assign own_req = (state == ST_OWN1) ? REQ1 : REQ0;
    assign oth_req = (state == ST_OWN1) ? REQ0 : REQ1;
    assign accept  = ACK0 | ACK1;
    // A tenure ends when the burst is exhausted or the owner drops its
    // request. Dropping the request is a release, not a transfer.
    assign release_now = !own_req || (accept && (cnt == CNT_LAST));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last;
        case (state)
            ST_IDLE: begin
                cnt_nxt = 4'd0;
                if (REQ0 && REQ1)
                    state_nxt = last ? ST_OWN0 : ST_OWN1;
                else if (REQ0)
                    state_nxt = ST_OWN0;
                else if (REQ1)
                    state_nxt = ST_OWN1;
            end
            ST_OWN0, ST_OWN1: begin
                if (release_now) begin
                    last_nxt = (state == ST_OWN1);
                    cnt_nxt  = 4'd0;
                    // Hand off with no bubble. If the other producer is
                    // quiet, a still-requesting owner starts a fresh tenure.
                    if (oth_req)
                        state_nxt = (state == ST_OWN0) ? ST_OWN1 : ST_OWN0;
                    else if (own_req)
                        state_nxt = state;
                    else
                        state_nxt = ST_IDLE;
                end else if (accept) begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            last  <= 1'b1;   // producer 0 wins the first tie
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            last  <= last_nxt;
        end
    end

endmodule
